// File: rtl/bias_cal_pkg.sv
// bias_cal_pkg: calibrator FSM state encoding and 50 MHz tick defaults
package bias_cal_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_SETTLE = 3'd2,
    S_LISTEN = 3'd3,
    S_EVAL   = 3'd4,
    S_DONE   = 3'd5,
    S_FAIL   = 3'd6,
    S_PARK   = 3'd7
  } state_t;
  localparam int CLK_MHZ = 50;
  function automatic int us_to_ticks(input int us);
    return us * CLK_MHZ;
  endfunction
  localparam int SETTLE_TICKS_DEF = us_to_ticks(5);
  localparam int LISTEN_TICKS_DEF = us_to_ticks(115);
endpackage

// File: rtl/bias_ramp_calibrator_tick_timer.sv
// tick_timer: loadable down-counter; done_o marks the terminal count while enabled
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = en_i && cnt_q == '0;
  assign cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bias_ramp_calibrator.sv
// bias_ramp_calibrator: ramps a DAC bias code until CONFIRM_WINDOWS noisy windows lock it.
// Define CAL_MARGIN_EN to back the locked code off by MARGIN and write it to the DAC.
module bias_ramp_calibrator
  import bias_cal_pkg::*;
#(
  parameter int CODE_W          = 8,
  parameter int START_CODE      = 0,
  parameter int STEP            = 1,
  parameter int MAX_CODE        = 2**CODE_W-1,
  parameter int SETTLE_TICKS    = SETTLE_TICKS_DEF,
  parameter int LISTEN_TICKS    = LISTEN_TICKS_DEF,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int MARGIN          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              noise_valid,
  output logic [CODE_W-1:0] dac_code,
  output logic              dac_req,
  input  logic              dac_ack,
  output logic [CODE_W-1:0] cal_code,
  output logic              cal_valid,
  output logic              busy,
  output logic              fail,
  output logic [2:0]        dbg_state,
  output logic [3:0]        dbg_hits
);
`ifdef CAL_MARGIN_EN
  localparam bit MARGIN_EN = 1'b1;
`else
  localparam bit MARGIN_EN = 1'b0;
`endif
  localparam int TW = $clog2((SETTLE_TICKS > LISTEN_TICKS ? SETTLE_TICKS : LISTEN_TICKS) + 1);
  state_t            state_q;
  logic [CODE_W-1:0] code_q, cal_q, margin_code;
  logic [CODE_W:0]   next_code;
  logic [3:0]        hits_q, hits_inc;
  logic              req_q, valid_q, noisy_q, pend_q, mwr_q;
  logic              t_load, t_en, t_done;
  logic [TW-1:0]     t_val;
  assign next_code   = {1'b0, code_q} + (CODE_W+1)'(STEP);
  assign margin_code = int'(code_q) >= MARGIN ? code_q - CODE_W'(MARGIN) : '0;
  assign hits_inc    = hits_q + 4'd1;
  // The timer is reloaded for SETTLE while writing/evaluating and for LISTEN as SETTLE expires.
  assign t_load = state_q == S_WRITE || state_q == S_EVAL || (state_q == S_SETTLE && t_done);
  assign t_val  = state_q == S_SETTLE ? TW'(LISTEN_TICKS - 1) : TW'(SETTLE_TICKS - 1);
  assign t_en   = state_q == S_SETTLE || state_q == S_LISTEN;
  tick_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load_i(t_load), .load_val_i(t_val), .en_i(t_en), .done_o(t_done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      cal_q   <= '0;
      hits_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      noisy_q <= 1'b0;
      pend_q  <= 1'b0;
      mwr_q   <= 1'b0;
    end else if (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL) begin
      if (start) begin
        state_q <= S_WRITE;
        code_q  <= CODE_W'(START_CODE);
        hits_q  <= '0;
        valid_q <= 1'b0;
        req_q   <= 1'b1;
        mwr_q   <= 1'b0;
      end
    end else if (abort && state_q != S_PARK) begin
      // An unacknowledged write must finish before the park write of 0 goes out.
      state_q <= S_PARK;
      pend_q  <= state_q == S_WRITE && !dac_ack;
      code_q  <= (state_q == S_WRITE && !dac_ack) ? code_q : '0;
      req_q   <= 1'b1;
      mwr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_WRITE:
          if (dac_ack) begin
            req_q   <= 1'b0;
            valid_q <= mwr_q;
            mwr_q   <= 1'b0;
            state_q <= mwr_q ? S_DONE : S_SETTLE;
          end
        S_SETTLE:
          if (t_done) begin
            noisy_q <= 1'b0;
            state_q <= S_LISTEN;
          end
        S_LISTEN: begin
          noisy_q <= noisy_q | noise_valid;
          if (t_done) state_q <= S_EVAL;
        end
        S_EVAL:
          if (noisy_q) begin
            hits_q <= hits_inc;
            if (hits_inc == 4'(CONFIRM_WINDOWS)) begin
              cal_q <= MARGIN_EN ? margin_code : code_q;
              if (MARGIN_EN) begin
                code_q  <= margin_code;
                req_q   <= 1'b1;
                mwr_q   <= 1'b1;
                state_q <= S_WRITE;
              end else begin
                valid_q <= 1'b1;
                state_q <= S_DONE;
              end
            end else state_q <= S_SETTLE;
          end else begin
            hits_q <= '0;
            if (next_code > (CODE_W+1)'(MAX_CODE)) state_q <= S_FAIL;
            else begin
              code_q  <= next_code[CODE_W-1:0];
              req_q   <= 1'b1;
              state_q <= S_WRITE;
            end
          end
        S_PARK:
          if (dac_ack) begin
            pend_q <= 1'b0;
            code_q <= '0;
            req_q  <= pend_q;
            if (!pend_q) state_q <= S_IDLE;
          end
        default: ;
      endcase
    end
  assign dac_code  = code_q;
  assign dac_req   = req_q;
  assign cal_code  = cal_q;
  assign cal_valid = valid_q;
  assign busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign fail      = state_q == S_FAIL;
  assign dbg_state = state_q;
  assign dbg_hits  = hits_q;
endmodule

// File: doc/bias_ramp_calibrator.md
Name: bias_ramp_calibrator

Overview:
Parametrised successor to the diode bias ramp controller. It steps a DAC bias code upward and writes each code to the DAC through a req/ack handshake. After each write it waits a settle time, then listens for noise over a fixed window. It locks the calibrated code once CONFIRM_WINDOWS consecutive windows contain noise. It sits between the top-level control, the SPI DAC writer and the noise comparator; its result feeds the calibration store.

Parameters:
CODE_W, 8, DAC code width in bits
START_CODE, 0, first code written after start
STEP, 1, code increment after a quiet window
MAX_CODE, 2**CODE_W-1, highest code allowed; stepping past it is a failure
SETTLE_TICKS, 250, clk cycles between dac_ack and the listen window (5 us at 50 MHz)
LISTEN_TICKS, 5750, clk cycles in one listen window (115 us at 50 MHz)
CONFIRM_WINDOWS, 3, consecutive noisy windows required to lock (range 1..15)
MARGIN, 4, back-off subtracted under CAL_MARGIN_EN

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  one-cycle pulse that begins calibration; honoured in IDLE, DONE and FAIL only
abort  in  1  one-cycle pulse that cancels an active calibration
noise_valid  in  1  level from the noise comparator, sampled every cycle
dac_code  out  CODE_W  code presented to the SPI writer
dac_req  out  1  write request, held high until dac_ack
dac_ack  in  1  one-cycle completion pulse from the SPI writer
cal_code  out  CODE_W  locked calibration code
cal_valid  out  1  high while cal_code holds a valid result
busy  out  1  high in every state except IDLE, DONE and FAIL
fail  out  1  high in FAIL
dbg_state  out  3  current state encoding
dbg_hits  out  4  current consecutive-noisy-window count

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: state = IDLE and every output is 0.
- State encodings: IDLE=0, WRITE=1, SETTLE=2, LISTEN=3, EVAL=4, DONE=5, FAIL=6, PARK=7.
- IDLE / DONE / FAIL on start:
  - code <= START_CODE, hits <= 0, cal_valid <= 0, fail <= 0.
  - Go to WRITE.
- WRITE:
  - dac_req = 1 and dac_code stays stable.
  - On dac_ack: dac_req <= 0, timer <= 0, go to SETTLE.
  - dac_ack outside WRITE/PARK is ignored.
- SETTLE: count SETTLE_TICKS cycles, then go to LISTEN with timer <= 0 and noisy <= 0.
- LISTEN:
  - Any cycle with noise_valid = 1 sets noisy.
  - After exactly LISTEN_TICKS cycles, go to EVAL.
  - Noise on the final listen cycle counts toward the window.
- EVAL (one cycle):
  - If noisy: hits <= hits+1. If hits+1 == CONFIRM_WINDOWS, go to DONE. Otherwise go to SETTLE; the code is held and not rewritten.
  - If quiet and code+STEP > MAX_CODE: go to FAIL. The comparison is computed CODE_W+1 wide, so there is no wrap.
  - Otherwise (quiet): hits <= 0, code <= code+STEP, go to WRITE.
- DONE: cal_code <= code and cal_valid <= 1 on entry; both hold until the next start or reset.
- FAIL: fail <= 1; cal_code is unchanged and dac_code holds its last value.
- abort in WRITE, SETTLE, LISTEN or EVAL:
  - Go to PARK, which writes code 0 via the same handshake. If PARK is entered from WRITE, the pending request completes first: the next dac_ack is consumed and then the 0 write is issued.
  - PARK → IDLE after its dac_ack.
  - abort in any other state is ignored. start during busy is ignored.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-handshake drops dac_req immediately; the SPI writer must tolerate an abandoned request.
- Latency: from start to the first dac_req is 1 cycle.

Optional Feature:
CAL_MARGIN_EN.
- Defined: on entering DONE, cal_code <= code−MARGIN, saturated at 0. DONE additionally writes that reduced code to the DAC through one WRITE handshake before cal_valid rises.
- Undefined: cal_code = code, no extra write, and the MARGIN parameter is unused.

Decomposition:
- Package bias_cal_pkg holds the state enumeration (3-bit encodings above) and the 50 MHz tick-conversion constants (settle and listen defaults).
- A natural sub-module is tick_timer: a loadable down-counter with a done pulse, width $clog2 of max(SETTLE_TICKS, LISTEN_TICKS)+1. It is shared by SETTLE and LISTEN.

Test Plan:
Bench parameters unless stated: CODE_W=8, START_CODE=0, STEP=1, SETTLE_TICKS=4, LISTEN_TICKS=8, CONFIRM_WINDOWS=3, ack returned 2 cycles after req.
1. Noise forced high from the window at code 5 onward → writes for codes 0..5 in order, then 3 windows at code 5 with no extra writes; DONE with cal_code=5, cal_valid=1, busy=0.
2. Noise pattern noisy, quiet, noisy, noisy, noisy starting at code 2 → hits go 1 then 0; code advances to 3; lock at cal_code=3.
3. MAX_CODE=6 with noise never asserted → last write is code 6, then FAIL with fail=1, cal_valid=0, dbg_state=6.
4. abort in LISTEN at code 4 → PARK issues a write of code 0, then IDLE; a later start restarts from code 0.
5. Reset asserted while dac_req=1 → all outputs are 0 asynchronously in the same cycle; after release a start gives a normal run.
6. With CAL_MARGIN_EN and MARGIN=4: lock at code 2 → cal_code=0 (saturated) and an extra DAC write of 0. Lock at code 9 → cal_code=5 and an extra write of 5.
